// File: rtl/mode_sequencer.sv
// mode_sequencer: debounces the MODE and LEARN buttons, steps the counter mode
// (SINGLE -> CARRY -> MAX) and sequences limit capture:
// hold the counter, capture the limit, clear the counter, then resume.
module mode_sequencer #(
    parameter int DIGITS          = 6,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_mode,
    input  logic                  btn_learn,
    input  logic [4*DIGITS-1:0]   cnt_in,
    output logic                  carry_set,
    output logic                  max_set,
    output logic                  refresh_limits,
    output logic                  cnt_hold,
    output logic                  cnt_clear,
    output logic                  limit_valid,
    output logic                  busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

    // Bit positions of the two buttons in the packed debounce vectors
    localparam int BTN_MODE  = 0;
    localparam int BTN_LEARN = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        CAPTURE = 3'd2,
        CLEAR   = 3'd3,
        RESUME  = 3'd4
    } learn_state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CARRY  = 2'd1,
        MODE_MAX    = 2'd2
    } mode_t;

    // Debounce pipeline: raw -> sync_p0 -> sync_p1 -> level_p2 -> level_p3/press_p3
    logic [1:0]      btn_raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      level_p2;
    logic [1:0]      level_p3;
    logic [1:0]      press_p3;
    logic [DB_W-1:0] stable_cnt [2];

    logic            mode_press;
    logic            learn_press;

    // Control state
    learn_state_t    state;
    learn_state_t    state_next;
    logic [ST_W-1:0] settle_cnt;
    logic [ST_W-1:0] settle_next;
    mode_t           mode;
    mode_t           mode_next;
    logic            pending;
    logic            pending_next;
    logic            limit_valid_next;

    // Mode rotation used by both direct and deferred mode presses
    function automatic mode_t step_mode(input mode_t m);
        case (m)
            MODE_SINGLE: return MODE_CARRY;
            MODE_CARRY:  return MODE_MAX;
            default:     return MODE_SINGLE;
        endcase
    endfunction

    assign btn_raw     = {btn_learn, btn_mode};
    assign mode_press  = press_p3[BTN_MODE];
    assign learn_press = press_p3[BTN_LEARN];

    // Synchronise both buttons, accept a level after DEBOUNCE_CYCLES stable samples, emit a rising-edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            level_p2 <= '0;
            level_p3 <= '0;
            press_p3 <= '0;
            for (int b = 0; b < 2; b++) begin
                stable_cnt[b] <= '0;
            end
        end else begin
            sync_p0  <= btn_raw;
            sync_p1  <= sync_p0;
            level_p3 <= level_p2;
            press_p3 <= level_p2 & ~level_p3;
            for (int b = 0; b < 2; b++) begin
                if (sync_p1[b] == level_p2[b]) begin
                    stable_cnt[b] <= '0;
                end else if (stable_cnt[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_cnt[b] <= '0;
                    level_p2[b]   <= sync_p1[b];
                end else begin
                    stable_cnt[b] <= stable_cnt[b] + DB_W'(1);
                end
            end
        end
    end

    // Next-state logic for the learn sequence, the mode register and the deferred mode press
    always_comb begin
        state_next       = state;
        settle_next      = settle_cnt;
        mode_next        = mode;
        pending_next     = pending;
        limit_valid_next = limit_valid;

        case (state)
            IDLE: begin
                if (pending) begin
                    // Deferred press is applied first; any new mode press this cycle is dropped
                    pending_next = 1'b0;
                    if (limit_valid) begin
                        mode_next = step_mode(mode);
                    end
                end else if (mode_press) begin
                    if (learn_press) begin
                        pending_next = 1'b1;
                    end else if (limit_valid) begin
                        mode_next = step_mode(mode);
                    end
                end
                if (learn_press) begin
                    state_next  = HOLD;
                    settle_next = '0;
                end
            end
            HOLD: begin
                if (settle_cnt == ST_W'(SETTLE_CYCLES - 1)) begin
                    state_next = CAPTURE;
                end else begin
                    settle_next = settle_cnt + ST_W'(1);
                end
            end
            CAPTURE: begin
                limit_valid_next = |cnt_in;
                if (!(|cnt_in)) begin
                    mode_next = MODE_SINGLE;
                end
                state_next = CLEAR;
            end
            CLEAR: begin
                state_next = RESUME;
            end
            RESUME: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A mode press while the sequence runs waits until the sequence is back in IDLE
        if ((state != IDLE) && mode_press && !pending) begin
            pending_next = 1'b1;
        end
    end

    // State registers and registered outputs decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            mode           <= MODE_SINGLE;
            pending        <= 1'b0;
            limit_valid    <= 1'b0;
            carry_set      <= 1'b0;
            max_set        <= 1'b0;
            refresh_limits <= 1'b0;
            cnt_hold       <= 1'b0;
            cnt_clear      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            settle_cnt     <= settle_next;
            mode           <= mode_next;
            pending        <= pending_next;
            limit_valid    <= limit_valid_next;
            carry_set      <= (mode_next == MODE_CARRY);
            max_set        <= (mode_next == MODE_MAX);
            refresh_limits <= (state_next == CAPTURE);
            cnt_hold       <= (state_next == HOLD) || (state_next == CAPTURE) || (state_next == CLEAR);
            cnt_clear      <= (state_next == CLEAR);
            busy           <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_mode_sequencer.sv
// Testbench for mode_sequencer: randomized button/limit scenarios checked against
// a transaction-level model (mode number modulo 3, limit-valid flag, press latencies).
module tb_mode_sequencer;

    localparam int DIGITS = 6;
    localparam int DB     = 16;
    localparam int SETTLE = 2;
    // Sample index (negedge after the k-th posedge from drive) at which a clean press pulse is visible
    localparam int LAT    = DB + 3;
    // Sample index of the capture cycle of a learn sequence
    localparam int CAP    = LAT + SETTLE + 1;

    logic                clk       = 1'b0;
    logic                reset     = 1'b1;
    logic                btn_mode  = 1'b0;
    logic                btn_learn = 1'b0;
    logic [4*DIGITS-1:0] cnt_in    = '0;
    logic                carry_set;
    logic                max_set;
    logic                refresh_limits;
    logic                cnt_hold;
    logic                cnt_clear;
    logic                limit_valid;
    logic                busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode 0=SINGLE 1=CARRY 2=MAX, and whether a non-zero limit is held
    int m_mode = 0;
    bit m_lv   = 1'b0;

    always #5 clk = ~clk;

    mode_sequencer #(
        .DIGITS(DIGITS),
        .DEBOUNCE_CYCLES(DB),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_learn(btn_learn),
        .cnt_in(cnt_in),
        .carry_set(carry_set),
        .max_set(max_set),
        .refresh_limits(refresh_limits),
        .cnt_hold(cnt_hold),
        .cnt_clear(cnt_clear),
        .limit_valid(limit_valid),
        .busy(busy)
    );

    // {carry_set, max_set, refresh_limits, cnt_hold, cnt_clear, limit_valid, busy}
    function automatic logic [6:0] outs();
        return {carry_set, max_set, refresh_limits, cnt_hold, cnt_clear, limit_valid, busy};
    endfunction

    function automatic logic [23:0] rand_nonzero();
        logic [23:0] v;
        v = 24'($urandom());
        if (v == 24'h0) v = 24'h000001;
        return v;
    endfunction

    // Hold one button high for len clock edges, then release
    task automatic drive_press(input bit is_learn, input int len);
        @(negedge clk);
        if (is_learn) btn_learn = 1'b1;
        else          btn_mode  = 1'b1;
        repeat (len) @(negedge clk);
        btn_learn = 1'b0;
        btn_mode  = 1'b0;
    endtask

    // Clean mode press, long enough wait for press and release to settle; model update
    task automatic do_mode_press();
        drive_press(1'b0, DB + 2);
        repeat (DB + 12) @(negedge clk);
        if (m_lv) m_mode = (m_mode + 1) % 3;
    endtask

    // Clean learn press capturing val; model update
    task automatic do_learn(input logic [23:0] val);
        cnt_in = val;
        drive_press(1'b1, DB + 4);
        repeat (DB + 25) @(negedge clk);
        m_lv = (val != 24'h0);
        if (!m_lv) m_mode = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_asserted actual=%b expected=%b", outs(), 7'b0);
        end
        reset = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 7'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d actual=%b expected=%b", k, outs(), 7'b0);
            end
        end
        m_mode = 0;
        m_lv   = 1'b0;
    endtask

    task automatic test_learn(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [23:0] val;
            int          pre;
            int          new_mode;
            bit          new_lv;
            logic [6:0]  exp_v;
            bit          e_cs, e_ms, e_lv;
            if (it == 0)                         val = 24'h000123;
            else if ($urandom_range(3, 0) == 0)  val = 24'h0;
            else                                 val = rand_nonzero();
            pre = (it == 0) ? 0 : $urandom_range(2, 0);
            for (int p = 0; p < pre; p++) begin
                do_mode_press();
                checks++;
                if ({carry_set, max_set} !== {m_mode == 1, m_mode == 2}) begin
                    errors++;
                    $display("FAIL learn_pre_mode actual=%b%b expected_mode=%0d", carry_set, max_set, m_mode);
                end
            end
            new_lv   = (val != 24'h0);
            new_mode = new_lv ? m_mode : 0;
            cnt_in   = val;
            @(negedge clk);
            btn_learn = 1'b1;
            for (int k = 1; k <= LAT + 50; k++) begin
                @(negedge clk);
                if (k == 40) btn_learn = 1'b0;
                e_cs  = (k >= CAP + 1) ? (new_mode == 1) : (m_mode == 1);
                e_ms  = (k >= CAP + 1) ? (new_mode == 2) : (m_mode == 2);
                e_lv  = (k >= CAP + 1) ? new_lv : m_lv;
                exp_v = {e_cs, e_ms, k == CAP, (k >= LAT + 1) && (k <= CAP + 1),
                         k == CAP + 1, e_lv, (k >= LAT + 1) && (k <= CAP + 2)};
                checks++;
                if (outs() !== exp_v) begin
                    errors++;
                    $display("FAIL learn_trace val=%h k=%0d actual=%b expected=%b", val, k, outs(), exp_v);
                end
            end
            m_lv   = new_lv;
            m_mode = new_mode;
        end
    endtask

    task automatic test_glitch();
        int lens[6];
        lens[0] = 3;
        for (int i = 1; i < 5; i++) lens[i] = $urandom_range(DB - 1, 1);
        lens[5] = DB - 1;
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                if (b == 0) btn_mode  = 1'b1;
                else        btn_learn = 1'b1;
                for (int k = 1; k <= 2 * DB + 10; k++) begin
                    @(negedge clk);
                    if (k == lens[i]) begin
                        btn_mode  = 1'b0;
                        btn_learn = 1'b0;
                    end
                    checks++;
                    if ({carry_set, max_set, cnt_hold, busy} !== {m_mode == 1, m_mode == 2, 1'b0, 1'b0}) begin
                        errors++;
                        $display("FAIL glitch len=%0d btn=%0d k=%0d actual=%b%b%b%b expected_mode=%0d",
                                 lens[i], b, k, carry_set, max_set, cnt_hold, busy, m_mode);
                    end
                end
            end
        end
        // A press of exactly DB cycles is long enough to count
        drive_press(1'b0, DB);
        repeat (DB + 12) @(negedge clk);
        if (m_lv) m_mode = (m_mode + 1) % 3;
        checks++;
        if ({carry_set, max_set} !== {m_mode == 1, m_mode == 2}) begin
            errors++;
            $display("FAIL press_exact_db actual=%b%b expected_mode=%0d", carry_set, max_set, m_mode);
        end
    endtask

    task automatic test_mode_cycle();
        if (!m_lv) do_learn(rand_nonzero());
        for (int p = 0; p < 4; p++) begin
            int old_mode;
            int nxt_mode;
            int e_mode;
            old_mode = m_mode;
            nxt_mode = (m_mode + 1) % 3;
            @(negedge clk);
            btn_mode = 1'b1;
            for (int k = 1; k <= DB + 30; k++) begin
                @(negedge clk);
                if (k == DB + 2) btn_mode = 1'b0;
                e_mode = (k >= LAT + 1) ? nxt_mode : old_mode;
                checks++;
                if ({carry_set, max_set} !== {e_mode == 1, e_mode == 2}) begin
                    errors++;
                    $display("FAIL mode_cycle press=%0d k=%0d actual=%b%b expected_mode=%0d",
                             p, k, carry_set, max_set, e_mode);
                end
            end
            m_mode = nxt_mode;
        end
    endtask

    task automatic test_zero_capture();
        if (!m_lv) do_learn(rand_nonzero());
        while (m_mode != 2) do_mode_press();
        checks++;
        if ({carry_set, max_set} !== 2'b01) begin
            errors++;
            $display("FAIL zero_setup_max actual=%b%b expected=01", carry_set, max_set);
        end
        do_learn(24'h0);
        checks++;
        if ({carry_set, max_set, limit_valid, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL zero_capture actual=%b%b%b%b expected=0000", carry_set, max_set, limit_valid, busy);
        end
        do_mode_press();
        checks++;
        if ({carry_set, max_set, limit_valid} !== 3'b000) begin
            errors++;
            $display("FAIL zero_mode_ignored actual=%b%b%b expected=000", carry_set, max_set, limit_valid);
        end
    endtask

    task automatic test_pending();
        for (int it = 0; it < 10; it++) begin
            int          off;
            logic [23:0] val;
            bit          cap_lv;
            int          cap_mode;
            int          fin_mode;
            int          e_mode;
            bit          e_busy;
            off      = (it < 7) ? it : $urandom_range(6, 0);
            val      = ($urandom_range(3, 0) == 0) ? 24'h0 : rand_nonzero();
            cap_lv   = (val != 24'h0);
            cap_mode = cap_lv ? m_mode : 0;
            fin_mode = cap_lv ? (cap_mode + 1) % 3 : 0;
            cnt_in   = val;
            @(negedge clk);
            btn_learn = 1'b1;
            if (off == 0) btn_mode = 1'b1;
            for (int k = 1; k <= CAP + 25; k++) begin
                @(negedge clk);
                if (k == off) btn_mode = 1'b1;
                if (k == DB + 4) btn_learn = 1'b0;
                if (k == off + DB + 4) btn_mode = 1'b0;
                e_mode = (k >= CAP + 4) ? fin_mode : ((k >= CAP + 1) ? cap_mode : m_mode);
                e_busy = (k >= LAT + 1) && (k <= CAP + 2);
                checks++;
                if ({carry_set, max_set, busy} !== {e_mode == 1, e_mode == 2, e_busy}) begin
                    errors++;
                    $display("FAIL pending off=%0d val=%h k=%0d actual=%b%b%b expected_mode=%0d busy=%0d",
                             off, val, k, carry_set, max_set, busy, e_mode, e_busy);
                end
            end
            repeat (30) @(negedge clk);
            m_mode = fin_mode;
            m_lv   = cap_lv;
        end
    endtask

    task automatic test_reset_mid();
        cnt_in = rand_nonzero();
        @(negedge clk);
        btn_learn = 1'b1;
        for (int k = 1; k <= CAP; k++) begin
            @(negedge clk);
            if (k == DB + 4) btn_learn = 1'b0;
        end
        checks++;
        if ({refresh_limits, cnt_hold} !== 2'b11) begin
            errors++;
            $display("FAIL capture_before_reset actual=%b%b expected=11", refresh_limits, cnt_hold);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_async actual=%b expected=%b", outs(), 7'b0);
        end
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        m_mode = 0;
        m_lv   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (outs() !== 7'b0) begin
                errors++;
                $display("FAIL reset_mid_after k=%0d actual=%b expected=%b", k, outs(), 7'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_learn(1);
        test_glitch();
        test_mode_cycle();
        test_learn(8);
        test_zero_capture();
        test_pending();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
